// File: rtl/cwe1280_req_arbiter.sv
// Round-robin burst-limited arbiter that tags the winning requester's beat with a fixed per-port user ID.
// Latency 1 (all outputs registered); no backpressure, req is a level valid and gnt acknowledges the beat taken.
module cwe1280_req_arbiter #(
    parameter int                      NUM_REQ   = 4,
    parameter int                      ID_W      = 3,
    parameter int                      DATA_W    = 8,
    parameter logic [NUM_REQ*ID_W-1:0] PORT_IDS  = 12'h8D1,
    parameter logic [ID_W-1:0]         IDLE_ID   = 3'h0,
    parameter int                      MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ID_W-1:0]           usr_id,
    output logic [DATA_W-1:0]         data_out,
    output logic                      out_valid
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]    usr_id_q, usr_id_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;

    logic               pick_vld;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   scan_ptr;
    logic [NUM_REQ-1:0] req_oth;
    logic               others_req;
    logic               emit;
    logic [PTR_W-1:0]   emit_idx;

    // Round-robin scan starting at rr_ptr; first asserted port wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_ptr = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_ptr = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!pick_vld && req[scan_ptr]) begin
                pick_vld = 1'b1;
                pick_idx = scan_ptr;
            end
        end
    end

    always_comb begin
        req_oth           = req;
        req_oth[owner_q]  = 1'b0;
        others_req        = |req_oth;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            gnt_q      <= '0;
            usr_id_q   <= IDLE_ID;
            data_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            gnt_q      <= gnt_d;
            usr_id_q   <= usr_id_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        emit       = 1'b0;
        emit_idx   = owner_q;
        case (state_q)
            ST_BUSY: begin
                if (req[owner_q] && ((beat_cnt_q < CNT_W'(MAX_BURST)) || !others_req)) begin
                    emit       = 1'b1;
                    beat_cnt_d = (beat_cnt_q == CNT_W'(MAX_BURST)) ? beat_cnt_q
                                                                   : beat_cnt_q + 1'b1;
                end else begin
                    // Any owner change must pass through the bubble cycle.
                    state_d  = ST_SWITCH;
                    rr_ptr_d = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: begin
                if (pick_vld) begin
                    state_d    = ST_BUSY;
                    owner_d    = pick_idx;
                    beat_cnt_d = CNT_W'(1);
                    emit       = 1'b1;
                    emit_idx   = pick_idx;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // ID comes only from the port index; a non-emitting cycle always drops to IDLE_ID.
    always_comb begin
        gnt_d    = '0;
        usr_id_d = IDLE_ID;
        data_d   = data_q;
        valid_d  = 1'b0;
        if (emit) begin
            gnt_d[emit_idx] = 1'b1;
            usr_id_d        = PORT_IDS[emit_idx*ID_W +: ID_W];
            data_d          = req_data[emit_idx*DATA_W +: DATA_W];
            valid_d         = 1'b1;
        end
    end

    assign gnt       = gnt_q;
    assign usr_id    = usr_id_q;
    assign data_out  = data_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_cwe1280_req_arbiter.sv
// Bench for cwe1280_req_arbiter: vector table through a scoreboard queue, plus async-reset sequences.
module tb_cwe1280_req_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt_a, gnt_b;
    logic [2:0]  id_a, id_b;
    logic [7:0]  d_a, d_b;
    logic        v_a, v_b;

    always #5 clk = ~clk;

    cwe1280_req_arbiter #(.MAX_BURST(4)) u_dut_a (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt_a), .usr_id(id_a), .data_out(d_a), .out_valid(v_a)
    );

    cwe1280_req_arbiter #(.MAX_BURST(1)) u_dut_b (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt_b), .usr_id(id_b), .data_out(d_b), .out_valid(v_b)
    );

    typedef struct {
        logic       sel;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [2:0] id;
        logic [7:0] dat;
        logic       vld;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_step = 0;

    function automatic void chk(input string name, input int idx,
                                input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, got, exp);
        end
    endfunction

    function automatic void add(input logic sel, input logic [3:0] r, input logic [3:0] g,
                                input logic [2:0] id, input logic [7:0] d, input logic v);
        vec_t e;
        e.sel = sel; e.req = r; e.gnt = g; e.id = id; e.dat = d; e.vld = v;
        tbl.push_back(e);
    endfunction

    function automatic void chk_reset(input string name, input int idx);
        chk({name, "_gnt"}, idx, gnt_a, 0);
        chk({name, "_id"},  idx, id_a,  0);
        chk({name, "_dat"}, idx, d_a,   0);
        chk({name, "_vld"}, idx, v_a,   0);
    endfunction

    // Called at a negedge: drive each vector, expect it one edge later.
    task automatic run_tbl();
        vec_t e;
        for (int i = 0; i < tbl.size(); i++) begin
            req = tbl[i].req;
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            if (e.sel) begin
                chk("b_gnt", n_step, gnt_b, e.gnt);
                chk("b_id",  n_step, id_b,  e.id);
                chk("b_dat", n_step, d_b,   e.dat);
                chk("b_vld", n_step, v_b,   e.vld);
            end else begin
                chk("a_gnt", n_step, gnt_a, e.gnt);
                chk("a_id",  n_step, id_a,  e.id);
                chk("a_dat", n_step, d_a,   e.dat);
                chk("a_vld", n_step, v_a,   e.vld);
            end
            n_step++;
            @(negedge clk);
        end
        tbl.delete();
    endtask

    initial begin
        rst      = 1'b1;
        req      = 4'b0000;
        req_data = 32'hA53C_2010;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("por", 0);
        @(negedge clk);
        rst = 1'b0;

        // Single requester, port3 privileged, then drop.
        add(0, 4'b1000, 4'b1000, 3'd4, 8'hA5, 1);
        add(0, 4'b0000, 4'b0000, 3'd0, 8'hA5, 0);
        add(0, 4'b0000, 4'b0000, 3'd0, 8'hA5, 0);
        // Burst limit between port0 and port1.
        for (int i = 0; i < 4; i++) add(0, 4'b0011, 4'b0001, 3'd1, 8'h10, 1);
        add(0, 4'b0011, 4'b0000, 3'd0, 8'h10, 0);
        for (int i = 0; i < 4; i++) add(0, 4'b0011, 4'b0010, 3'd2, 8'h20, 1);
        add(0, 4'b0011, 4'b0000, 3'd0, 8'h20, 0);
        add(0, 4'b0011, 4'b0001, 3'd1, 8'h10, 1);
        add(0, 4'b0000, 4'b0000, 3'd0, 8'h10, 0);
        add(0, 4'b0000, 4'b0000, 3'd0, 8'h10, 0);
        // Lone owner runs past the burst limit, then yields once contended.
        for (int i = 0; i < 10; i++) add(0, 4'b0100, 4'b0100, 3'd3, 8'h3C, 1);
        add(0, 4'b0101, 4'b0000, 3'd0, 8'h3C, 0);
        add(0, 4'b0101, 4'b0001, 3'd1, 8'h10, 1);
        add(0, 4'b0000, 4'b0000, 3'd0, 8'h10, 0);
        add(0, 4'b0000, 4'b0000, 3'd0, 8'h10, 0);
        // Owner drop and re-assert costs a bubble; sole requester wins again.
        add(0, 4'b0001, 4'b0001, 3'd1, 8'h10, 1);
        add(0, 4'b0000, 4'b0000, 3'd0, 8'h10, 0);
        add(0, 4'b0001, 4'b0001, 3'd1, 8'h10, 1);
        add(0, 4'b0000, 4'b0000, 3'd0, 8'h10, 0);
        add(0, 4'b0000, 4'b0000, 3'd0, 8'h10, 0);
        // Port3 owning, two beats in.
        add(0, 4'b1000, 4'b1000, 3'd4, 8'hA5, 1);
        add(0, 4'b1000, 4'b1000, 3'd4, 8'hA5, 1);
        run_tbl();

        // Asynchronous reset mid-burst with everyone requesting.
        req = 4'b1111;
        rst = 1'b1;
        #1;
        chk_reset("rst_now", 0);
        chk("rst_now_b_vld", 0, v_b, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_reset("rst_hold", i);
        end
        @(negedge clk);
        rst = 1'b0;
        add(0, 4'b1001, 4'b0001, 3'd1, 8'h10, 1);
        add(0, 4'b1001, 4'b0001, 3'd1, 8'h10, 1);
        run_tbl();

        // Fresh reset, then round-robin with MAX_BURST=1 on the second instance.
        rst = 1'b1;
        @(negedge clk);
        chk("rr_rst_b_id", 0, id_b, 0);
        rst = 1'b0;
        add(1, 4'b1111, 4'b0001, 3'd1, 8'h10, 1);
        add(1, 4'b1111, 4'b0000, 3'd0, 8'h10, 0);
        add(1, 4'b1111, 4'b0010, 3'd2, 8'h20, 1);
        add(1, 4'b1111, 4'b0000, 3'd0, 8'h20, 0);
        add(1, 4'b1111, 4'b0100, 3'd3, 8'h3C, 1);
        add(1, 4'b1111, 4'b0000, 3'd0, 8'h3C, 0);
        add(1, 4'b1111, 4'b1000, 3'd4, 8'hA5, 1);
        add(1, 4'b1111, 4'b0000, 3'd0, 8'hA5, 0);
        add(1, 4'b1111, 4'b0001, 3'd1, 8'h10, 1);
        run_tbl();

        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d entries left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
